// File: rtl/hsv_core_axil_arbiter_if.sv
// AXI-Lite bus bundle shared by the core masters, the arbiter and the memory interconnect.
// Every channel: a source raises valid without waiting for ready, then holds valid and payload
// steady until the edge where valid and ready are both high.
interface axil_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport m (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport s (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/hsv_core_axil_arbiter.sv
// 2:1 AXI-Lite arbiter: round-robin per channel, in-order response routing through
// small id FIFOs that remember which master issued each outstanding request.
module hsv_core_axil_arbiter_route_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] ids_q, ids_d;
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = ids_q[rptr_q];

  always_comb begin
    ids_d  = ids_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      ids_d[wptr_q] = push_id;
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
    end
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ids_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      ids_q  <= ids_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

module hsv_core_axil_arbiter #(
  parameter int MAX_PENDING = 4
) (
  input  logic clk_core,
  input  logic rst_core_n,
  axil_if.s    s0,
  axil_if.s    s1,
  axil_if.m    mem,
  output logic rd_owner,
  output logic wr_owner
);
  logic rd_lock_q, rd_lock_d, rd_grant_q, rd_grant_d, rd_last_q, rd_last_d;
  logic rd_own_q, rd_own_d, rd_sel, ar_hs, r_hs, rd_full, rd_empty, rd_head;
  logic wr_lock_q, wr_lock_d, wr_grant_q, wr_grant_d, wr_last_q, wr_last_d;
  logic wr_own_q, wr_own_d, wr_sel, aw_hs, w_hs, b_hs, wr_full, wr_empty, wr_head;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d, wr_done;

  // ---------------- read address channel ----------------
  always_comb begin
    if (rd_lock_q)                       rd_sel = rd_grant_q;
    else if (s0.arvalid && s1.arvalid)   rd_sel = ~rd_last_q;
    else                                 rd_sel = s1.arvalid;
  end

  assign mem.arvalid = ~rd_full & (rd_sel ? s1.arvalid : s0.arvalid);
  assign mem.araddr  = rd_sel ? s1.araddr : s0.araddr;
  assign mem.arprot  = rd_sel ? s1.arprot : s0.arprot;
  assign ar_hs       = mem.arvalid & mem.arready;
  assign s0.arready  = ar_hs & ~rd_sel;
  assign s1.arready  = ar_hs & rd_sel;
  assign rd_owner    = (rd_lock_q | mem.arvalid) ? rd_sel : rd_own_q;

  // A presented but unaccepted AR freezes the grant so the payload stays stable.
  always_comb begin
    rd_lock_d  = rd_lock_q;
    rd_grant_d = rd_grant_q;
    rd_last_d  = rd_last_q;
    rd_own_d   = rd_own_q;
    if (ar_hs) begin
      rd_lock_d = 1'b0;
      rd_last_d = rd_sel;
      rd_own_d  = rd_sel;
    end else if (mem.arvalid) begin
      rd_lock_d  = 1'b1;
      rd_grant_d = rd_sel;
    end
  end

  // ---------------- read data channel ----------------
  assign s0.rvalid  = mem.rvalid & ~rd_empty & ~rd_head;
  assign s1.rvalid  = mem.rvalid & ~rd_empty & rd_head;
  assign s0.rdata   = mem.rdata;
  assign s1.rdata   = mem.rdata;
  assign s0.rresp   = mem.rresp;
  assign s1.rresp   = mem.rresp;
  assign mem.rready = ~rd_empty & (rd_head ? s1.rready : s0.rready);
  assign r_hs       = mem.rvalid & mem.rready;

  hsv_core_axil_arbiter_route_fifo #(.DEPTH(MAX_PENDING)) u_rd_fifo (
    .clk(clk_core), .rst_n(rst_core_n), .push(ar_hs), .push_id(rd_sel), .pop(r_hs),
    .full(rd_full), .empty(rd_empty), .head(rd_head)
  );

  // ---------------- write address/data channels ----------------
  always_comb begin
    if (wr_lock_q)
      wr_sel = wr_grant_q;
    else if ((s0.awvalid | s0.wvalid) && (s1.awvalid | s1.wvalid))
      wr_sel = ~wr_last_q;
    else
      wr_sel = s1.awvalid | s1.wvalid;
  end

  assign mem.awvalid = ~wr_full & ~aw_done_q & (wr_sel ? s1.awvalid : s0.awvalid);
  assign mem.awaddr  = wr_sel ? s1.awaddr : s0.awaddr;
  assign mem.awprot  = wr_sel ? s1.awprot : s0.awprot;
  assign mem.wvalid  = ~wr_full & ~w_done_q & (wr_sel ? s1.wvalid : s0.wvalid);
  assign mem.wdata   = wr_sel ? s1.wdata : s0.wdata;
  assign mem.wstrb   = wr_sel ? s1.wstrb : s0.wstrb;
  assign aw_hs       = mem.awvalid & mem.awready;
  assign w_hs        = mem.wvalid & mem.wready;
  assign s0.awready  = aw_hs & ~wr_sel;
  assign s1.awready  = aw_hs & wr_sel;
  assign s0.wready   = w_hs & ~wr_sel;
  assign s1.wready   = w_hs & wr_sel;
  assign wr_done     = (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign wr_owner    = (wr_lock_q | mem.awvalid | mem.wvalid) ? wr_sel : wr_own_q;

  // The grant holds until both AW and W have completed, in whichever order.
  always_comb begin
    wr_lock_d  = wr_lock_q;
    wr_grant_d = wr_grant_q;
    wr_last_d  = wr_last_q;
    wr_own_d   = wr_own_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    if (wr_done) begin
      wr_lock_d = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      wr_last_d = wr_sel;
      wr_own_d  = wr_sel;
    end else if (mem.awvalid | mem.wvalid | aw_done_q | w_done_q) begin
      wr_lock_d  = 1'b1;
      wr_grant_d = wr_sel;
      aw_done_d  = aw_done_q | aw_hs;
      w_done_d   = w_done_q | w_hs;
    end
  end

  // ---------------- write response channel ----------------
  assign s0.bvalid  = mem.bvalid & ~wr_empty & ~wr_head;
  assign s1.bvalid  = mem.bvalid & ~wr_empty & wr_head;
  assign s0.bresp   = mem.bresp;
  assign s1.bresp   = mem.bresp;
  assign mem.bready = ~wr_empty & (wr_head ? s1.bready : s0.bready);
  assign b_hs       = mem.bvalid & mem.bready;

  hsv_core_axil_arbiter_route_fifo #(.DEPTH(MAX_PENDING)) u_wr_fifo (
    .clk(clk_core), .rst_n(rst_core_n), .push(wr_done), .push_id(wr_sel), .pop(b_hs),
    .full(wr_full), .empty(wr_empty), .head(wr_head)
  );

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      rd_lock_q  <= 1'b0;
      rd_grant_q <= 1'b0;
      rd_last_q  <= 1'b1;
      rd_own_q   <= 1'b0;
      wr_lock_q  <= 1'b0;
      wr_grant_q <= 1'b0;
      wr_last_q  <= 1'b1;
      wr_own_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_lock_q  <= rd_lock_d;
      rd_grant_q <= rd_grant_d;
      rd_last_q  <= rd_last_d;
      rd_own_q   <= rd_own_d;
      wr_lock_q  <= wr_lock_d;
      wr_grant_q <= wr_grant_d;
      wr_last_q  <= wr_last_d;
      wr_own_q   <= wr_own_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Responses may only arrive for requests that were issued through this arbiter.
  a_r_no_orphan: assert property (@(posedge clk_core) disable iff (!rst_core_n)
                                  !(mem.rvalid && rd_empty));
  a_b_no_orphan: assert property (@(posedge clk_core) disable iff (!rst_core_n)
                                  !(mem.bvalid && wr_empty));
endmodule

// File: tb/tb_hsv_core_axil_arbiter.sv
// Directed bench for the 2:1 AXI-Lite arbiter: grant order, lock stability, FIFO back-pressure,
// split AW/W writes, streamed writes with random bready, and asynchronous reset.
module tb_hsv_core_axil_arbiter;
  logic clk_core = 1'b0;
  logic rst_core_n = 1'b0;
  logic rd_owner, wr_owner;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_q[$];

  axil_if s0_if ();
  axil_if s1_if ();
  axil_if mem_if ();

  hsv_core_axil_arbiter #(.MAX_PENDING(4)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n),
    .s0(s0_if), .s1(s1_if), .mem(mem_if),
    .rd_owner(rd_owner), .wr_owner(wr_owner)
  );

  // ---------------- clock ----------------
  always #5 clk_core = ~clk_core;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk_core);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    s0_if.awaddr = '0; s0_if.awprot = '0; s0_if.awvalid = 0; s0_if.wdata = '0;
    s0_if.wstrb = '1; s0_if.wvalid = 0; s0_if.bready = 0; s0_if.araddr = '0;
    s0_if.arprot = '0; s0_if.arvalid = 0; s0_if.rready = 0;
    s1_if.awaddr = '0; s1_if.awprot = '0; s1_if.awvalid = 0; s1_if.wdata = '0;
    s1_if.wstrb = '1; s1_if.wvalid = 0; s1_if.bready = 0; s1_if.araddr = '0;
    s1_if.arprot = '0; s1_if.arvalid = 0; s1_if.rready = 0;
    mem_if.awready = 0; mem_if.wready = 0; mem_if.bresp = '0; mem_if.bvalid = 0;
    mem_if.arready = 0; mem_if.rdata = '0; mem_if.rresp = '0; mem_if.rvalid = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nacc;
    int outst;
    logic exp_next;
    logic got_id;

    idle_all();
    repeat (3) @(posedge clk_core);
    #1;
    check("rst_arvalid", mem_if.arvalid, 0);
    check("rst_awvalid", mem_if.awvalid, 0);
    check("rst_wvalid", mem_if.wvalid, 0);
    check("rst_rready", mem_if.rready, 0);
    check("rst_bready", mem_if.bready, 0);
    check("rst_owners", {rd_owner, wr_owner}, 0);
    rst_core_n = 1'b1;

    // 1: simultaneous reads -> s0 then s1, R routed in order
    s0_if.arvalid = 1; s0_if.araddr = 32'h100;
    s1_if.arvalid = 1; s1_if.araddr = 32'h200;
    mem_if.arready = 1;
    settle();
    check("t1_ar0_addr", mem_if.araddr, 32'h100);
    check("t1_ar0_rdy", {s0_if.arready, s1_if.arready}, 2'b10);
    check("t1_rd_owner0", rd_owner, 0);
    tick();
    s0_if.arvalid = 0;
    settle();
    check("t1_ar1_addr", mem_if.araddr, 32'h200);
    check("t1_ar1_rdy", {s0_if.arready, s1_if.arready}, 2'b01);
    check("t1_rd_owner1", rd_owner, 1);
    tick();
    s1_if.arvalid = 0; mem_if.arready = 0;
    mem_if.rvalid = 1; mem_if.rdata = 32'haaaa; s0_if.rready = 1; s1_if.rready = 1;
    settle();
    check("t1_r0_route", {s0_if.rvalid, s1_if.rvalid}, 2'b10);
    check("t1_r0_data", s0_if.rdata, 32'haaaa);
    tick();
    mem_if.rdata = 32'hbbbb;
    settle();
    check("t1_r1_route", {s0_if.rvalid, s1_if.rvalid}, 2'b01);
    check("t1_r1_data", s1_if.rdata, 32'hbbbb);
    tick();
    mem_if.rvalid = 0;
    settle();
    check("t1_empty_rready", mem_if.rready, 0);

    // 2: stalled s1 AR keeps its grant while s0 competes
    tick();
    s1_if.arvalid = 1; s1_if.araddr = 32'h300;
    settle();
    check("t2_first_addr", mem_if.araddr, 32'h300);
    tick();
    s0_if.arvalid = 1; s0_if.araddr = 32'h400;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t2_lock_addr", mem_if.araddr, 32'h300);
      check("t2_lock_owner", rd_owner, 1);
      check("t2_lock_s0rdy", s0_if.arready, 0);
      tick();
    end
    mem_if.arready = 1;
    settle();
    check("t2_s1_accept", s1_if.arready, 1);
    tick();
    s1_if.arvalid = 0;
    settle();
    check("t2_s0_next", {s0_if.arready, mem_if.araddr}, {1'b1, 32'h400});
    tick();
    s0_if.arvalid = 0; mem_if.arready = 0; mem_if.rvalid = 1;
    settle();
    check("t2_r_first", {s0_if.rvalid, s1_if.rvalid}, 2'b01);
    tick();
    settle();
    check("t2_r_second", {s0_if.rvalid, s1_if.rvalid}, 2'b10);
    tick();
    mem_if.rvalid = 0;

    // 3: 4 outstanding reads fill the route FIFO; 5th waits for an R pop
    s0_if.arvalid = 1; s0_if.araddr = 32'h500; mem_if.arready = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t3_accept", s0_if.arready, 1);
      tick();
    end
    settle();
    check("t3_full_arvalid", mem_if.arvalid, 0);
    check("t3_full_arready", s0_if.arready, 0);
    tick();
    mem_if.rvalid = 1;
    settle();
    check("t3_full_pop_cycle", {mem_if.arvalid, mem_if.rready}, 2'b01);
    tick();
    mem_if.rvalid = 0;
    settle();
    check("t3_resume", {mem_if.arvalid, s0_if.arready}, 2'b11);
    tick();
    s0_if.arvalid = 0; mem_if.arready = 0; mem_if.rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t3_drain", {s0_if.rvalid, s1_if.rvalid}, 2'b10);
      tick();
    end
    mem_if.rvalid = 0;
    settle();
    check("t3_drained", mem_if.rready, 0);

    // 4: s0 W two cycles ahead of AW; s1 waits, then wins
    tick();
    s0_if.wvalid = 1; s0_if.wdata = 32'h55; mem_if.wready = 1;
    settle();
    check("t4_w_first", {mem_if.wvalid, s0_if.wready, mem_if.awvalid}, 3'b110);
    tick();
    s0_if.wvalid = 0;
    s1_if.awvalid = 1; s1_if.awaddr = 32'h600; s1_if.wvalid = 1; s1_if.wdata = 32'h66;
    mem_if.awready = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("t4_hold", {mem_if.awvalid, mem_if.wvalid, s1_if.awready, wr_owner}, 4'b0000);
      tick();
    end
    s0_if.awvalid = 1; s0_if.awaddr = 32'h500;
    settle();
    check("t4_aw_s0", {mem_if.awvalid, s0_if.awready, mem_if.awaddr}, {2'b11, 32'h500});
    tick();
    s0_if.awvalid = 0;
    settle();
    check("t4_s1_grant", {s1_if.awready, s1_if.wready, wr_owner}, 3'b111);
    check("t4_s1_wdata", mem_if.wdata, 32'h66);
    tick();
    s1_if.awvalid = 0; s1_if.wvalid = 0; mem_if.awready = 0; mem_if.wready = 0;
    mem_if.bvalid = 1; s0_if.bready = 1; s1_if.bready = 1;
    settle();
    check("t4_b0", {s0_if.bvalid, s1_if.bvalid}, 2'b10);
    tick();
    settle();
    check("t4_b1", {s0_if.bvalid, s1_if.bvalid}, 2'b01);
    tick();
    mem_if.bvalid = 0;
    settle();
    check("t4_b_empty", mem_if.bready, 0);

    // 5: both masters stream 8 writes; grants alternate from s0, Bs return to issuers
    tick();
    nacc = 0; outst = 0; exp_next = 0;
    s0_if.awvalid = 1; s0_if.wvalid = 1; s1_if.awvalid = 1; s1_if.wvalid = 1;
    mem_if.awready = 1; mem_if.wready = 1;
    for (int cyc = 0; cyc < 300 && (nacc < 8 || outst > 0); cyc++) begin
      if (nacc >= 8) begin
        s0_if.awvalid = 0; s0_if.wvalid = 0; s1_if.awvalid = 0; s1_if.wvalid = 0;
      end
      mem_if.bvalid = (outst > 0);
      s0_if.bready = 1'($urandom_range(0, 1));
      s1_if.bready = 1'($urandom_range(0, 1));
      settle();
      if (mem_if.awvalid && mem_if.awready) begin
        got_id = s1_if.awready;
        check("t5_grant", got_id, exp_next);
        check("t5_w_with_aw", {s0_if.wready, s1_if.wready}, {~exp_next, exp_next});
        exp_q.push_back(32'(exp_next));
        exp_next = ~exp_next;
        nacc++;
        outst++;
      end
      if (mem_if.bvalid && mem_if.bready) begin
        got_id = s1_if.bvalid;
        if (exp_q.size() > 0) check("t5_b_route", got_id, exp_q.pop_front());
        else check("t5_b_extra", 1, 0);
        outst--;
      end
      tick();
    end
    mem_if.bvalid = 0; mem_if.awready = 0; mem_if.wready = 0;
    s0_if.awvalid = 0; s0_if.wvalid = 0; s1_if.awvalid = 0; s1_if.wvalid = 0;
    check("t5_accepted", nacc, 8);
    check("t5_outstanding", outst, 0);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: async reset with 2 reads outstanding
    s1_if.arvalid = 1; s1_if.araddr = 32'h700; mem_if.arready = 1;
    tick();
    s1_if.arvalid = 0; s0_if.arvalid = 1; s0_if.araddr = 32'h800;
    tick();
    s0_if.arvalid = 0; mem_if.arready = 0;
    mem_if.rvalid = 1; s0_if.rready = 1; s1_if.rready = 1;
    settle();
    check("t6_pre_rvalid", {s0_if.rvalid, s1_if.rvalid}, 2'b01);
    rst_core_n = 1'b0;
    #1;
    check("t6_rst_rvalid", {s0_if.rvalid, s1_if.rvalid}, 2'b00);
    check("t6_rst_rready", mem_if.rready, 0);
    mem_if.rvalid = 0;
    tick();
    tick();
    rst_core_n = 1'b1;
    settle();
    check("t6_empty_after", mem_if.rready, 0);
    s0_if.arvalid = 1; s0_if.araddr = 32'h900; s1_if.arvalid = 1; s1_if.araddr = 32'ha00;
    mem_if.arready = 1;
    settle();
    check("t6_s0_first", {s0_if.arready, s1_if.arready, rd_owner}, 3'b100);
    tick();
    s0_if.arvalid = 0;
    settle();
    check("t6_s1_second", s1_if.arready, 1);
    tick();
    s1_if.arvalid = 0; mem_if.arready = 0; mem_if.rvalid = 1;
    settle();
    check("t6_r0", {s0_if.rvalid, s1_if.rvalid}, 2'b10);
    tick();
    settle();
    check("t6_r1", {s0_if.rvalid, s1_if.rvalid}, 2'b01);
    tick();
    mem_if.rvalid = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
